// File: rtl/trace_pkg.sv
// rtl/trace_pkg.sv - shared trace types, default widths and RISC-V control-flow opcode constants
package trace_pkg;

  localparam int TRACE_ADDR_WIDTH = 64;
  localparam int TRACE_FIFO_DEPTH = 16;
  localparam int TRACE_GAP_WIDTH  = 16;
  localparam int TRACE_LOST_WIDTH = 32;

  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [1:0] C_OP_Q1      = 2'b01;
  localparam logic [1:0] C_OP_Q2      = 2'b10;
  localparam logic [2:0] C_F3_JAL     = 3'b001;
  localparam logic [2:0] C_F3_J       = 3'b101;
  localparam logic [2:0] C_F3_BEQZ    = 3'b110;
  localparam logic [2:0] C_F3_BNEZ    = 3'b111;
  localparam logic [2:0] C_F3_JR_JALR = 3'b100;

  typedef struct packed {
    logic [TRACE_ADDR_WIDTH-1:0] pc;
    logic [31:0]                 instr;
    logic [TRACE_GAP_WIDTH-1:0]  gap;
  } trace_entry_t;

  // Coarse control-flow test used by the filter; compressed JR/JALR also match C.MV/C.ADD.
  function automatic logic is_control_flow(input logic [31:0] instr);
    if (instr[1:0] == 2'b11)
      return (instr[6:0] == OPC_BRANCH) || (instr[6:0] == OPC_JAL) || (instr[6:0] == OPC_JALR);
    else if (instr[1:0] == C_OP_Q1)
      return (instr[15:13] == C_F3_JAL) || (instr[15:13] == C_F3_J) ||
             (instr[15:13] == C_F3_BEQZ) || (instr[15:13] == C_F3_BNEZ);
    else
      return (instr[1:0] == C_OP_Q2) && (instr[15:13] == C_F3_JR_JALR);
  endfunction

endpackage

// File: rtl/trace_fifo.sv
// rtl/trace_fifo.sv - parameterised first-word fall-through synchronous FIFO
module trace_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_q;
  logic [PW-1:0]    rd_q;
  logic [PW:0]      level_q;
  logic             do_push;
  logic             do_pop;

  assign empty_o = (level_q == '0);
  assign full_o  = (level_q == (PW+1)'(DEPTH));
  assign level_o = level_q;
  assign data_o  = empty_o ? '0 : mem_q[rd_q];

  // When full, a same-cycle pop frees the slot the write pointer already targets.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_q    <= '0;
      rd_q    <= '0;
      level_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= data_i;
        wr_q        <= wr_q + 1'b1;
      end
      if (do_pop)
        rd_q <= rd_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

endmodule

// File: rtl/trace_collector.sv
// rtl/trace_collector.sv - aligns trace stream with drop flag, buffers kept entries; TRACE_COLLECTOR_GAP_COUNT_EN enables gap counting
module trace_collector
  import trace_pkg::*;
#(
  parameter int ADDR_WIDTH = TRACE_ADDR_WIDTH,
  parameter int FIFO_DEPTH = TRACE_FIFO_DEPTH,
  parameter int GAP_WIDTH  = TRACE_GAP_WIDTH,
  parameter int LOST_WIDTH = TRACE_LOST_WIDTH
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          trace_valid,
  input  logic [ADDR_WIDTH-1:0]         trace_pc,
  input  logic [31:0]                   trace_instr,
  input  logic                          drop_instr,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [ADDR_WIDTH-1:0]         out_pc,
  output logic [31:0]                   out_instr,
  output logic [GAP_WIDTH-1:0]          out_gap,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  output logic [LOST_WIDTH-1:0]         lost_count,
  input  logic                          clear_overflow
);

`ifdef TRACE_COLLECTOR_GAP_COUNT_EN
  localparam int ENTRY_W = ADDR_WIDTH + 32 + GAP_WIDTH;
`else
  localparam int ENTRY_W = ADDR_WIDTH + 32;
`endif

  logic                  s1_valid_q;
  logic [ADDR_WIDTH-1:0] s1_pc_q;
  logic [31:0]           s1_instr_q;
  logic                  overflow_q;
  logic [LOST_WIDTH-1:0] lost_q;
  logic                  kept;
  logic                  pop;
  logic                  full;
  logic                  empty;
  logic                  loss;
  logic [ENTRY_W-1:0]    push_data;
  logic [ENTRY_W-1:0]    head_data;

  // The filter's decision lags the instruction by one clock, so hold the instruction here.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_pc_q    <= '0;
      s1_instr_q <= '0;
    end else begin
      s1_valid_q <= trace_valid;
      s1_pc_q    <= trace_pc;
      s1_instr_q <= trace_instr;
    end
  end

  assign kept      = s1_valid_q && !drop_instr;
  assign out_valid = !empty;
  assign pop       = out_valid && out_ready;
  assign loss      = kept && full && !pop;

`ifdef TRACE_COLLECTOR_GAP_COUNT_EN
  logic [GAP_WIDTH-1:0] gap_q;

  always_ff @(posedge clk) begin
    if (rst)
      gap_q <= '0;
    else if (kept)
      gap_q <= '0;
    else if (s1_valid_q && gap_q != '1)
      gap_q <= gap_q + 1'b1;
  end

  assign push_data                    = {s1_pc_q, s1_instr_q, gap_q};
  assign {out_pc, out_instr, out_gap} = head_data;
`else
  assign push_data           = {s1_pc_q, s1_instr_q};
  assign {out_pc, out_instr} = head_data;
  assign out_gap             = '0;
`endif

  // A loss in the same cycle as a clear leaves exactly that one loss recorded.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_q <= 1'b0;
      lost_q     <= '0;
    end else if (loss) begin
      overflow_q <= 1'b1;
      if (clear_overflow)
        lost_q <= {{(LOST_WIDTH-1){1'b0}}, 1'b1};
      else if (lost_q != '1)
        lost_q <= lost_q + 1'b1;
    end else if (clear_overflow) begin
      overflow_q <= 1'b0;
      lost_q     <= '0;
    end
  end

  assign overflow   = overflow_q;
  assign lost_count = lost_q;

  trace_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_i   (rst),
    .push_i  (kept),
    .data_i  (push_data),
    .pop_i   (pop),
    .data_o  (head_data),
    .full_o  (full),
    .empty_o (empty),
    .level_o (fifo_level)
  );

endmodule

// File: tb/tb_trace_collector.sv
// tb/tb_trace_collector.sv - scoreboard bench for trace_collector
module tb_trace_collector;

  logic        clk;
  logic        rst;
  logic        trace_valid;
  logic [63:0] trace_pc;
  logic [31:0] trace_instr;
  logic        drop_instr;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_pc;
  logic [31:0] out_instr;
  logic [15:0] out_gap;
  logic [4:0]  fifo_level;
  logic        overflow;
  logic [31:0] lost_count;
  logic        clear_overflow;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
    logic [15:0] gap;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  trace_collector #(
    .ADDR_WIDTH (64),
    .FIFO_DEPTH (16),
    .GAP_WIDTH  (16),
    .LOST_WIDTH (32)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .trace_valid    (trace_valid),
    .trace_pc       (trace_pc),
    .trace_instr    (trace_instr),
    .drop_instr     (drop_instr),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_instr      (out_instr),
    .out_gap        (out_gap),
    .fifo_level     (fifo_level),
    .overflow       (overflow),
    .lost_count     (lost_count),
    .clear_overflow (clear_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  function automatic logic [15:0] gexp(input int g);
`ifdef TRACE_COLLECTOR_GAP_COUNT_EN
    return 16'(g);
`else
    return (g == 0) ? 16'd0 : 16'd0;
`endif
  endfunction

  // One clock: present an instruction (or idle) plus the drop decision for last cycle's instruction.
  task automatic cyc(input logic v, input logic [63:0] pc, input logic [31:0] ins, input logic drop);
    trace_valid = v;
    trace_pc    = pc;
    trace_instr = ins;
    drop_instr  = drop;
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pop", {32'd0, out_instr}, 64'hdead_0000);
      end else begin
        e = exp_q.pop_front();
        check("out_pc", out_pc, e.pc);
        check("out_instr", {32'd0, out_instr}, {32'd0, e.instr});
        check("out_gap", {48'd0, out_gap}, {48'd0, e.gap});
      end
    end
  end

  initial begin
    rst = 1'b1;
    out_ready = 1'b0;
    clear_overflow = 1'b0;
    cyc(0, 64'd0, 32'd0, 0);
    cyc(0, 64'd0, 32'd0, 0);
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_level", {59'd0, fifo_level}, 64'd0);
    check("rst_overflow", {63'd0, overflow}, 64'd0);
    check("rst_lost", {32'd0, lost_count}, 64'd0);
    check("rst_out_pc", out_pc, 64'd0);
    check("rst_out_gap", {48'd0, out_gap}, 64'd0);
    rst = 1'b0;

    // Ordering and latency
    out_ready = 1'b1;
    exp_q.push_back('{pc: 64'h1000, instr: 32'h0000_006F, gap: 16'd0});
    cyc(1, 64'h1000, 32'h0000_006F, 0);
    check("lat_cycle1_valid", {63'd0, out_valid}, 64'd0);
    cyc(0, 64'd0, 32'd0, 0);
    check("lat_cycle2_valid", {63'd0, out_valid}, 64'd1);
    cyc(0, 64'd0, 32'd0, 0);
    cyc(0, 64'd0, 32'd0, 0);

    // Gap counting: five drops, then two kept entries back to back
    exp_q.push_back('{pc: 64'h2010, instr: 32'h0000_0063, gap: gexp(5)});
    exp_q.push_back('{pc: 64'h2014, instr: 32'h0000_8067, gap: gexp(0)});
    for (int k = 0; k < 8; k++)
      cyc(k < 7, 64'h1FFC + 64'(4 * k),
          (k == 5) ? 32'h0000_0063 : (k == 6) ? 32'h0000_8067 : 32'h0000_0013,
          (k >= 1 && k <= 5));
    cyc(0, 64'd0, 32'd0, 0);
    cyc(0, 64'd0, 32'd0, 0);

    // Full FIFO; drop flag while stage empty must not disturb the gap
    out_ready = 1'b0;
    cyc(0, 64'd0, 32'd0, 1);
    cyc(0, 64'd0, 32'd0, 1);
    for (int k = 0; k < 18; k++) begin
      if (k < 16)
        exp_q.push_back('{pc: 64'h3000 + 64'(4 * k), instr: 32'h0000_0063 | 32'(k << 12), gap: 16'd0});
      cyc(1, 64'h3000 + 64'(4 * k), 32'h0000_0063 | 32'(k << 12), 0);
      if (k == 16) begin
        check("full_level", {59'd0, fifo_level}, 64'd16);
        check("full_no_overflow", {63'd0, overflow}, 64'd0);
      end
    end
    cyc(0, 64'd0, 32'd0, 0);
    check("loss_count", {32'd0, lost_count}, 64'd2);
    check("loss_overflow", {63'd0, overflow}, 64'd1);
    check("loss_level", {59'd0, fifo_level}, 64'd16);
    check("loss_head_pc", out_pc, 64'h3000);

    // Push with pop while full
    cyc(1, 64'h3100, 32'h0000_8067, 0);
    out_ready = 1'b1;
    cyc(0, 64'd0, 32'd0, 0);
    out_ready = 1'b0;
    exp_q.push_back('{pc: 64'h3100, instr: 32'h0000_8067, gap: 16'd0});
    check("pushpop_level", {59'd0, fifo_level}, 64'd16);
    check("pushpop_lost", {32'd0, lost_count}, 64'd2);

    // Clear versus loss in the same cycle, then a plain clear
    cyc(1, 64'h3200, 32'h0000_0063, 0);
    clear_overflow = 1'b1;
    cyc(0, 64'd0, 32'd0, 0);
    clear_overflow = 1'b0;
    check("clrloss_overflow", {63'd0, overflow}, 64'd1);
    check("clrloss_lost", {32'd0, lost_count}, 64'd1);
    clear_overflow = 1'b1;
    cyc(0, 64'd0, 32'd0, 0);
    clear_overflow = 1'b0;
    check("clear_overflow", {63'd0, overflow}, 64'd0);
    check("clear_lost", {32'd0, lost_count}, 64'd0);
    check("clear_level", {59'd0, fifo_level}, 64'd16);

    // Drain everything buffered
    out_ready = 1'b1;
    for (int i = 0; i < 40 && out_valid; i++)
      cyc(0, 64'd0, 32'd0, 0);
    check("drain_out_valid", {63'd0, out_valid}, 64'd0);
    check("drain_scoreboard_empty", 64'(exp_q.size()), 64'd0);
    check("empty_out_pc", out_pc, 64'd0);

    // Reset mid-operation with seven buffered and one in the stage
    out_ready = 1'b0;
    for (int k = 0; k < 8; k++)
      cyc(1, 64'h4000 + 64'(4 * k), 32'h0000_006F, 0);
    check("pre_reset_level", {59'd0, fifo_level}, 64'd7);
    rst = 1'b1;
    cyc(0, 64'd0, 32'd0, 0);
    rst = 1'b0;
    check("midrst_out_valid", {63'd0, out_valid}, 64'd0);
    check("midrst_level", {59'd0, fifo_level}, 64'd0);
    check("midrst_lost", {32'd0, lost_count}, 64'd0);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++)
      cyc(0, 64'd0, 32'd0, 0);
    check("post_rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("post_rst_level", {59'd0, fifo_level}, 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/trace_collector.md
Name: trace_collector

Overview:
- Downstream consumer of the trace filter's per-instruction drop decision.
- Aligns the committed-instruction stream with the registered drop flag, which arrives one clock later.
- Discards dropped entries and buffers kept (branch/jump/return) entries in a FIFO.
- Presents kept entries to the trace reader/DMA side over a valid/ready handshake, with a drop-gap count and overflow accounting.

Parameters:
- ADDR_WIDTH, 64: width of trace PC.
- FIFO_DEPTH, 16: kept-entry buffer depth; power of 2, at least 2.
- GAP_WIDTH, 16: width of the dropped-instruction gap counter.
- LOST_WIDTH, 32: width of the lost-entry counter.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- trace_valid  input  1  a committed instruction is present this cycle
- trace_pc  input  ADDR_WIDTH  PC of that instruction
- trace_instr  input  32  instruction word (the same word fed to the filter this cycle)
- drop_instr  input  1  filter decision for the instruction presented the previous cycle
- out_valid  output  1  FIFO head entry available
- out_ready  input  1  consumer accepts head entry
- out_pc  output  ADDR_WIDTH  head entry PC
- out_instr  output  32  head entry instruction
- out_gap  output  GAP_WIDTH  dropped instructions preceding the head entry
- fifo_level  output  $clog2(FIFO_DEPTH)+1  current occupancy
- overflow  output  1  sticky: at least one kept entry was lost
- lost_count  output  LOST_WIDTH  saturating count of lost kept entries
- clear_overflow  input  1  clears overflow and lost_count

Behaviour:
- Reset (synchronous, rst=1):
  - Pipeline stage valid cleared; FIFO empty; out_valid=0; fifo_level=0; overflow=0; lost_count=0; gap counter=0.
  - out_pc, out_instr and out_gap are 0 while empty.
- Alignment stage:
  - Each cycle registers trace_valid, trace_pc and trace_instr into s1_valid, s1_pc and s1_instr.
  - drop_instr in cycle N+1 qualifies the stage contents captured at edge N.
  - drop_instr is ignored when s1_valid=0.
- Classification, when s1_valid=1:
  - drop_instr=1: gap counter increments, saturating at 2^GAP_WIDTH-1.
  - drop_instr=0: a kept entry {s1_pc, s1_instr, gap} is a push candidate; the gap counter resets to 0 in the same cycle, whether or not the push succeeds.
- FIFO:
  - Synchronous, first-word fall-through. The head is visible on out_* while out_valid=1.
  - A pop occurs when out_valid && out_ready.
  - Push succeeds if not full, or if full and a pop occurs in the same cycle. Occupancy is unchanged in the second case.
  - Push into an empty FIFO: out_valid rises the cycle after the push edge, so latency from trace_valid to out_valid is 2 cycles.
  - Pointers wrap modulo FIFO_DEPTH; fifo_level is exact, 0..FIFO_DEPTH.
- Overflow:
  - A push candidate rejected because the FIFO is full with no pop: entry discarded, overflow set, lost_count incremented (saturating at all-ones).
  - clear_overflow zeroes both on the next edge.
  - If clear_overflow and a loss occur in the same cycle, the loss wins: overflow=1, lost_count=1.
- Handshake:
  - out_* are stable while out_valid=1 and out_ready=0.
  - out_ready while out_valid=0 has no effect.
- Reset mid-operation: all buffered entries are discarded; no partial entry is emitted afterwards.

Optional Feature:
- Macro: TRACE_COLLECTOR_GAP_COUNT_EN.
- Defined:
  - Gap counter is implemented and stored per FIFO entry.
  - out_gap reports the number of dropped instructions between the previous kept entry and this one.
- Undefined:
  - No gap counter or gap storage.
  - out_gap is tied to 0; port list unchanged.

Decomposition:
- Shared package trace_pkg:
  - trace entry struct typedef {pc, instr, gap}.
  - RISC-V branch/JAL/JALR opcode constants and compressed funct constants, shared with the filter.
  - Default width constants.
- One sub-module, trace_fifo: parameterised FWFT synchronous FIFO with push/pop/full/empty/level. It is reused by other trace buffers.

Test Plan:
- Ordering and latency: reset, then trace_valid with pc=0x1000 instr=0x0000006F (JAL), drop_instr=0 next cycle, out_ready=1 → out_valid=1 exactly 2 cycles after input, with out_pc=0x1000, out_instr=0x0000006F, out_gap=0.
- Gap counting (GAP_COUNT_EN defined): 5 dropped entries (drop=1), then a kept branch at pc=0x2010 → out_gap=5; the next kept entry immediately after → out_gap=0.
- Full FIFO: out_ready=0, 16 kept entries → fifo_level=16, overflow=0. 17th and 18th kept entries → lost_count=2, overflow=1, FIFO contents unchanged.
- Push with pop while full: full FIFO, out_ready=1 and a kept entry in the same cycle → no loss, fifo_level stays 16, FIFO order preserved.
- Clear vs. loss: clear_overflow asserted in the same cycle as a loss → overflow=1, lost_count=1.
- Reset mid-operation: reset asserted with fifo_level=7 → next cycle out_valid=0, fifo_level=0, lost_count=0, and the stage entry from the cycle before reset is never emitted.
